// File: rtl/sprite_render_sequencer_if.sv
// Handshake and strobe bundle between the sprite render sequencer and its
// surroundings (frame timing, datapath done flags, datapath control strobes).
//   frame_tick, pause, sprite_en, bg_done, draw_done, erase_done : into sequencer
//   draw_bg, ld_spr, draw_spr, erase_spr, update_spr, writeEn,
//   spr_sel, frame_cnt                                           : out of sequencer
// slave  = the sequencer side, master = the environment/datapath side.
interface sprite_render_sequencer_if #(
  parameter int N_SPR = 4,
  parameter int SEL_W = 2,
  parameter int CNT_W = 4
);
  logic             frame_tick;
  logic             pause;
  logic [N_SPR-1:0] sprite_en;
  logic             bg_done;
  logic             draw_done;
  logic             erase_done;
  logic             draw_bg;
  logic             ld_spr;
  logic             draw_spr;
  logic             erase_spr;
  logic             update_spr;
  logic             writeEn;
  logic [SEL_W-1:0] spr_sel;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output frame_tick, pause, sprite_en, bg_done, draw_done, erase_done,
    input  draw_bg, ld_spr, draw_spr, erase_spr, update_spr, writeEn,
           spr_sel, frame_cnt
  );

  modport slave (
    input  frame_tick, pause, sprite_en, bg_done, draw_done, erase_done,
    output draw_bg, ld_spr, draw_spr, erase_spr, update_spr, writeEn,
           spr_sel, frame_cnt
  );
endinterface

// File: rtl/sprite_render_sequencer.sv
// Control FSM for the VGA game renderer. Fills the background once after
// reset, then loops draw / wait / erase / update over up to N_SPR sprites,
// presenting one sprite at a time to the shared datapath via spr_sel.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   bus    - sprite_render_sequencer_if.slave: frame timing, enable mask,
//            datapath done flags in; Moore strobes, spr_sel, frame_cnt out
module sprite_render_sequencer #(
  parameter int N_SPR     = 4,
  parameter int SEL_W     = 2,
  parameter int FRAME_DIV = 15,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic reset,
  sprite_render_sequencer_if.slave bus
);

  localparam int               SPAN     = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_SPR - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_DIV - 1);

  typedef enum logic [2:0] {
    S_BG,
    S_DSCAN,
    S_LOAD,
    S_DRAW,
    S_WAIT,
    S_ESCAN,
    S_ERASE,
    S_UPDATE
  } state_t;

  state_t           state, state_n;
  logic [SEL_W-1:0] sel, sel_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N_SPR-1:0] en_q, en_n;

  // Zero-extended mask so spr_sel can index it even when N_SPR < 2^SEL_W.
  logic [SPAN-1:0]  en_wide;
  logic             slot_on;
  logic             last_slot;

  assign en_wide   = SPAN'(en_q);
  assign slot_on   = en_wide[sel];
  assign last_slot = (sel == LAST_SEL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_BG;
      sel   <= '0;
      cnt   <= '0;
      en_q  <= '0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      cnt   <= cnt_n;
      en_q  <= en_n;
    end
  end

  always_comb begin
    state_n        = state;
    sel_n          = sel;
    cnt_n          = cnt;
    en_n           = en_q;
    bus.draw_bg    = 1'b0;
    bus.ld_spr     = 1'b0;
    bus.draw_spr   = 1'b0;
    bus.erase_spr  = 1'b0;
    bus.update_spr = 1'b0;
    bus.writeEn    = 1'b0;

    // Every path that starts a new draw phase at slot 0 also snapshots the
    // enable mask, so the erase phase that follows sees the same set.
    unique case (state)
      S_BG: begin
        bus.draw_bg = 1'b1;
        bus.writeEn = 1'b1;
        if (bus.bg_done) begin
          state_n = S_DSCAN;
          sel_n   = '0;
          cnt_n   = '0;
          en_n    = bus.sprite_en;
        end
      end

      S_DSCAN: begin
        if (slot_on) begin
          state_n = S_LOAD;
        end else if (last_slot) begin
          state_n = S_WAIT;
        end else begin
          sel_n = sel + SEL_W'(1);
        end
      end

      S_LOAD: begin
        bus.ld_spr = 1'b1;
        state_n    = S_DRAW;
      end

      S_DRAW: begin
        bus.draw_spr = 1'b1;
        bus.writeEn  = 1'b1;
        if (bus.draw_done) begin
          if (last_slot) begin
            state_n = S_WAIT;
          end else begin
            state_n = S_DSCAN;
            sel_n   = sel + SEL_W'(1);
            cnt_n   = '0;
          end
        end
      end

      S_WAIT: begin
        if (bus.frame_tick && !bus.pause) begin
          if (cnt == LAST_CNT) begin
            cnt_n   = '0;
            sel_n   = '0;
            state_n = S_ESCAN;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end

      S_ESCAN: begin
        if (slot_on) begin
          state_n = S_ERASE;
        end else if (last_slot) begin
          state_n = S_DSCAN;
          sel_n   = '0;
          cnt_n   = '0;
          en_n    = bus.sprite_en;
        end else begin
          sel_n = sel + SEL_W'(1);
        end
      end

      S_ERASE: begin
        bus.erase_spr = 1'b1;
        bus.writeEn   = 1'b1;
        if (bus.erase_done) begin
          state_n = S_UPDATE;
        end
      end

      S_UPDATE: begin
        bus.update_spr = 1'b1;
        if (last_slot) begin
          state_n = S_DSCAN;
          sel_n   = '0;
          cnt_n   = '0;
          en_n    = bus.sprite_en;
        end else begin
          state_n = S_ESCAN;
          sel_n   = sel + SEL_W'(1);
        end
      end
    endcase
  end

  assign bus.spr_sel   = sel;
  assign bus.frame_cnt = cnt;

endmodule

// File: tb/tb_sprite_render_sequencer.sv
module tb_sprite_render_sequencer;

  localparam logic [5:0] O_I  = 6'b000000;  // {draw_bg,ld,draw,erase,update,writeEn}
  localparam logic [5:0] O_BG = 6'b100001;
  localparam logic [5:0] O_LD = 6'b010000;
  localparam logic [5:0] O_DR = 6'b001001;
  localparam logic [5:0] O_ER = 6'b000101;
  localparam logic [5:0] O_UP = 6'b000010;

  localparam logic [3:0] MA = 4'b0101;
  localparam logic [3:0] MB = 4'b1010;
  localparam logic [3:0] MF = 4'b1111;
  localparam logic [3:0] MZ = 4'b0000;

  typedef struct {
    logic       rst, ft, ps;
    logic [3:0] en;
    logic       bg, dd, ed;
    logic [5:0] strb;
    logic [1:0] sel;
    logic [3:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];
  int   seg1, seg2, seg3;

  always #5 clk = ~clk;

  sprite_render_sequencer_if #(.N_SPR(4), .SEL_W(2), .CNT_W(4)) bus ();

  sprite_render_sequencer #(
    .N_SPR(4), .SEL_W(2), .FRAME_DIV(15), .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic add(input logic rst, ft, ps, input logic [3:0] en,
                     input logic bg, dd, ed, input logic [5:0] strb,
                     input logic [1:0] sel, input logic [3:0] cnt);
    vec_t t;
    t.rst = rst; t.ft = ft; t.ps = ps; t.en = en;
    t.bg = bg; t.dd = dd; t.ed = ed;
    t.strb = strb; t.sel = sel; t.cnt = cnt;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [5:0] strb,
                     input logic [1:0] sel, input logic [3:0] cnt);
    logic [5:0] a;
    a = {bus.draw_bg, bus.ld_spr, bus.draw_spr, bus.erase_spr,
         bus.update_spr, bus.writeEn};
    checks++;
    if (a !== strb || bus.spr_sel !== sel || bus.frame_cnt !== cnt) begin
      failures++;
      $display("FAIL %s: got strb=%b sel=%0d cnt=%0d, want strb=%b sel=%0d cnt=%0d",
               nm, a, bus.spr_sel, bus.frame_cnt, strb, sel, cnt);
    end
  endtask

  // One cycle: drive inputs sampled at the next posedge, check the Moore
  // outputs of the state entered at the previous posedge.
  task automatic cyc(input string nm, input logic rst, ft, ps,
                     input logic [3:0] en, input logic bg, dd, ed,
                     input logic [5:0] strb, input logic [1:0] sel,
                     input logic [3:0] cnt);
    @(negedge clk);
    reset          = rst;
    bus.frame_tick = ft;
    bus.pause      = ps;
    bus.sprite_en  = en;
    bus.bg_done    = bg;
    bus.draw_done  = dd;
    bus.erase_done = ed;
    chk(nm, strb, sel, cnt);
  endtask

  task automatic run_tbl(input int lo, input int hi);
    for (int i = lo; i < hi; i++)
      cyc($sformatf("vec%0d", i), tbl[i].rst, tbl[i].ft, tbl[i].ps, tbl[i].en,
          tbl[i].bg, tbl[i].dd, tbl[i].ed, tbl[i].strb, tbl[i].sel, tbl[i].cnt);
  endtask

  task automatic wait_ticks(input string nm, input logic [3:0] en, input int n);
    for (int i = 0; i < n; i++)
      cyc(nm, 0, 1, 0, en, 0, 0, 0, O_I, 2'd3, 4'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic ps;

    // Segment 1: reset, background, draw phase with mask 0101, start of wait.
    for (int i = 0; i < 5; i++) add(0,0,0,MA,0,0,0,O_BG,0,0);
    add(0,0,0,MA,1,0,0,O_BG,0,0);   // bg_done in cycle 5
    add(0,0,0,MA,0,0,0,O_I ,0,0);   // DSCAN 0
    add(0,0,0,MA,0,0,0,O_LD,0,0);   // LOAD 0 in cycle 7
    add(0,0,0,MA,0,1,0,O_DR,0,0);   // DRAW 0, done on entry
    add(0,0,0,MA,0,0,0,O_I ,1,0);   // DSCAN 1 (disabled)
    add(0,0,0,MA,0,0,0,O_I ,2,0);   // DSCAN 2
    add(0,0,0,MA,0,0,0,O_LD,2,0);
    add(0,0,0,MA,0,0,1,O_DR,2,0);   // spurious erase_done ignored
    add(0,1,0,MA,0,1,0,O_DR,2,0);   // tick outside WAIT ignored
    add(0,1,0,MA,0,0,0,O_I ,3,0);   // DSCAN 3 disabled, last -> WAIT
    add(0,1,0,MB,0,0,0,O_I ,3,0);   // WAIT, counted tick, mask changes
    add(0,0,0,MB,1,1,1,O_I ,3,1);   // spurious done pulses in WAIT
    add(0,1,1,MB,0,0,0,O_I ,3,1);   // paused tick
    add(0,0,0,MB,0,0,0,O_I ,3,1);
    seg1 = tbl.size();
    // Segment 2: erase of the latched 0101 set, then draw of 1010.
    add(0,0,0,MB,0,0,0,O_I ,0,0);   // ESCAN 0
    add(0,0,0,MB,0,0,1,O_ER,0,0);   // ERASE 0, done on entry
    add(0,0,0,MB,0,0,0,O_UP,0,0);
    add(0,0,0,MB,0,0,0,O_I ,1,0);
    add(0,0,0,MB,0,0,0,O_I ,2,0);
    add(0,0,0,MB,0,1,0,O_ER,2,0);   // spurious draw_done
    add(0,0,0,MB,0,0,1,O_ER,2,0);
    add(0,0,0,MB,0,0,0,O_UP,2,0);
    add(0,0,0,MB,0,0,0,O_I ,3,0);   // ESCAN 3 disabled -> DSCAN, mask 1010
    add(0,0,0,MB,0,0,0,O_I ,0,0);
    add(0,0,0,MB,0,0,0,O_I ,1,0);
    add(0,0,0,MB,0,0,0,O_LD,1,0);
    add(0,0,0,MB,0,1,0,O_DR,1,0);
    add(0,0,0,MB,0,0,0,O_I ,2,0);
    add(0,0,0,MB,0,0,0,O_I ,3,0);
    add(0,0,0,MB,0,0,0,O_LD,3,0);
    add(0,1,0,MB,0,1,0,O_DR,3,0);   // tick on DRAW->WAIT not counted
    add(0,0,0,MF,0,0,0,O_I ,3,0);   // WAIT, cnt still 0
    seg2 = tbl.size();
    // Segment 3: erase of latched 1010 with erase_done held high.
    add(0,0,0,MF,0,0,1,O_I ,0,0);
    add(0,0,0,MF,0,0,1,O_I ,1,0);
    add(0,0,0,MF,0,0,1,O_ER,1,0);
    add(0,0,0,MF,0,0,1,O_UP,1,0);
    add(0,0,0,MF,0,0,1,O_I ,2,0);
    add(0,0,0,MF,0,0,1,O_I ,3,0);
    add(0,0,0,MF,0,0,1,O_ER,3,0);
    add(0,0,0,MF,0,0,1,O_UP,3,0);
    seg3 = tbl.size();

    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.pause      = 1'b0;
    bus.sprite_en  = MA;
    bus.bg_done    = 1'b0;
    bus.draw_done  = 1'b0;
    bus.erase_done = 1'b0;
    repeat (2) @(posedge clk);

    run_tbl(0, seg1);

    // Divider with pause: 18 ticks in total, 3 of them paused.
    c = 1;
    for (int k = 0; k < 15; k++) begin
      ps = (k >= 3 && k <= 4);
      cyc("div_pause", 0, 1, ps, MB, 0, 0, 0, O_I, 2'd3, 4'(c));
      if (!ps) c++;
    end
    cyc("div_exit", 0, 1, 0, MB, 0, 0, 0, O_I, 2'd3, 4'd14);

    run_tbl(seg1, seg2);
    wait_ticks("div_full", MF, 15);
    run_tbl(seg2, seg3);

    // Full mask: draw_done three cycles into each DRAW, 20 cycles to WAIT.
    for (int s = 0; s < 4; s++) begin
      cyc("full_scan", 0, 0, 0, MF, 0, 0, 0, O_I , 2'(s), 4'd0);
      cyc("full_load", 0, 0, 0, MF, 0, 0, 0, O_LD, 2'(s), 4'd0);
      cyc("full_draw", 0, 0, 0, MF, 0, 0, 0, O_DR, 2'(s), 4'd0);
      cyc("full_draw", 0, 0, 0, MF, 0, 0, 0, O_DR, 2'(s), 4'd0);
      cyc("full_draw", 0, 0, 0, MF, 0, 1, 0, O_DR, 2'(s), 4'd0);
    end
    cyc("full_wait", 0, 0, 0, MF, 0, 0, 0, O_I, 2'd3, 4'd0);
    wait_ticks("div_full2", MF, 15);

    // Reset while erasing slot 2.
    cyc("rst_escan0", 0, 0, 0, MF, 0, 0, 1, O_I , 2'd0, 4'd0);
    cyc("rst_erase0", 0, 0, 0, MF, 0, 0, 1, O_ER, 2'd0, 4'd0);
    cyc("rst_upd0",   0, 0, 0, MF, 0, 0, 1, O_UP, 2'd0, 4'd0);
    cyc("rst_escan1", 0, 0, 0, MF, 0, 0, 1, O_I , 2'd1, 4'd0);
    cyc("rst_erase1", 0, 0, 0, MF, 0, 0, 1, O_ER, 2'd1, 4'd0);
    cyc("rst_upd1",   0, 0, 0, MF, 0, 0, 1, O_UP, 2'd1, 4'd0);
    cyc("rst_escan2", 0, 0, 0, MF, 0, 0, 0, O_I , 2'd2, 4'd0);
    cyc("rst_erase2", 1, 0, 0, MF, 0, 0, 0, O_ER, 2'd2, 4'd0);
    cyc("rst_bg",     0, 0, 0, MZ, 0, 0, 0, O_BG, 2'd0, 4'd0);
    cyc("rst_bg2",    0, 0, 0, MZ, 1, 0, 0, O_BG, 2'd0, 4'd0);

    // All-zero mask: N_SPR scan cycles per phase, no strobes.
    for (int s = 0; s < 4; s++)
      cyc("zero_dscan", 0, 0, 0, MZ, 0, 1, 1, O_I, 2'(s), 4'd0);
    cyc("zero_wait", 0, 0, 0, MZ, 0, 0, 0, O_I, 2'd3, 4'd0);
    for (int i = 1; i < 15; i++)
      cyc("zero_div", 0, 1, 0, MZ, 0, 0, 0, O_I, 2'd3, 4'(i - 1));
    cyc("zero_div_exit", 0, 1, 0, MZ, 0, 0, 0, O_I, 2'd3, 4'd14);
    for (int s = 0; s < 4; s++)
      cyc("zero_escan", 0, 0, 0, MZ, 0, 1, 1, O_I, 2'(s), 4'd0);
    cyc("zero_redraw", 0, 0, 0, MZ, 0, 0, 0, O_I, 2'd0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
